pipelined_bk_adder: RTL and testbench
=====================================

PIPELINED_BK_ADDER -- requirements
Module: pipelined_bk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a power of two, 4..64.
REQ-002 Port clk  input  1  single clock; all flops SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port in_valid  input  1  operand beat offered.
REQ-005 Port in_ready  output  1  block accepts a beat this cycle.
REQ-006 Port a, b  input  WIDTH each  operands.
REQ-007 Port cin  input  1  carry-in.
REQ-008 Port out_valid  output  1  result beat present.
REQ-009 Port out_ready  input  1  downstream accepts the result.
REQ-010 Port s  output  WIDTH  sum, a+b+cin modulo 2^WIDTH.
REQ-011 Port cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-012 A beat SHALL be accepted when in_valid && in_ready; a result SHALL be delivered when out_valid && out_ready.
REQ-013 Pipeline SHALL have three register stages: S1 registers bitwise generate a&b, propagate a^b and cin; S2 registers Brent-Kung prefix carries for all bits; S3 registers s and cout.
REQ-014 Latency with no backpressure SHALL be 3 cycles from acceptance to out_valid; throughput SHALL be one beat per cycle.
REQ-015 Each stage SHALL hold a valid bit; stage k SHALL load when it is empty or stage k+1 loads in the same cycle (bubble collapsing).
REQ-016 in_ready SHALL be combinationally (!S1.valid || S1 loads); out_valid SHALL equal S3.valid.
REQ-017 While out_valid && !out_ready, s and cout SHALL be held stable and no beat SHALL be lost or duplicated.
REQ-018 Beats SHALL emerge in acceptance order.
REQ-019 Prefix tree SHALL use the Brent-Kung up-sweep/down-sweep topology: 2*log2(WIDTH)-1 combine levels, all within S2.
REQ-020 Carry into bit 0 SHALL be cin; cout SHALL be the group generate of bits WIDTH-1..0 with cin folded in.
REQ-021 When in_valid is low, stage data registers MAY hold stale values, but valid bits SHALL be cleared as beats drain.

Reset
REQ-022 Asserting rst SHALL immediately clear all three valid bits; out_valid SHALL read 0 and in_ready SHALL read 1 while rst is high.
REQ-023 s and cout SHALL reset to 0; other data registers need no reset.
REQ-024 Beats in flight when rst asserts mid-operation SHALL be discarded; the first beat after deassertion SHALL appear after exactly 3 cycles.

Configuration
REQ-025 Macro PIPELINED_BK_ADDER_SUB_EN SHALL, when defined, add input port sub (1 bit, sampled with a/b); sub=1 SHALL compute a + ~b + 1 (cin ignored), cout=1 meaning no borrow.
REQ-026 Without PIPELINED_BK_ADDER_SUB_EN the port sub SHALL NOT exist and behaviour SHALL be REQ-010/011 only.

Structure
REQ-027 Package adder_pkg SHALL hold the generate/propagate pair typedef, the default width constant and a log2 depth function.
REQ-028 Sub-module bk_prefix_cell SHALL implement the (g,p) combine: g = gh | (ph & gl), p = ph & pl; it SHALL be instantiated throughout the tree.
REQ-029 RTL SHALL be synthesizable, with no latches and no multicycle paths.

Verification
REQ-030 WIDTH=16, a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 3 cycles later s=0x0000, cout=1.
REQ-031 Back-to-back 8 beats a=i, b=2*i, cin=1 with out_ready=1 -> out_valid 8 consecutive cycles, s=3*i+1, in order.
REQ-032 out_ready=0 for 5 cycles while streaming -> in_ready drops after 3 beats are held, s stable, no loss after release.
REQ-033 rst pulsed with 2 beats in flight -> out_valid 0 immediately, neither beat emitted; the next beat appears 3 cycles after acceptance.
REQ-034 SUB_EN defined, a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0; a=7, b=5 -> s=0x0002, cout=1.
REQ-035 Random sweep of WIDTH in {4,8,32,64} against a behavioural a+b+cin model -> zero mismatches over 10k beats with random backpressure.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined Brent-Kung adder.
package adder_pkg;

    localparam int unsigned DefaultWidth = 16;

    // Generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned log2_depth(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung (g,p) combine cell: merges a high group with the adjacent low group.
module bk_prefix_cell
    import adder_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t grp
);

    assign grp.g = hi.g | (hi.p & lo.g);
    assign grp.p = hi.p & lo.p;

endmodule

// File: rtl/pipelined_bk_adder.sv
// Three-stage valid/ready Brent-Kung adder. Define PIPELINED_BK_ADDER_SUB_EN to add a
// 'sub' input that computes a + ~b + 1 (cout=1 means no borrow).
module pipelined_bk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_BK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int unsigned Log2W     = log2_depth(WIDTH);
    localparam int unsigned NumLevels = 2 * Log2W - 1;

    if ((32'd1 << Log2W) != WIDTH || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("WIDTH must be a power of two in 4..64");
    end

    // ------------------------------------------------------------------
    // Handshake: a stage loads when empty or when its successor loads.
    // ------------------------------------------------------------------
    logic valid1_q, valid2_q, valid3_q;
    logic load1, load2, load3;

    assign load3     = !valid3_q || out_ready;
    assign load2     = !valid2_q || load3;
    assign load1     = !valid1_q || load2;
    assign in_ready  = load1;
    assign out_valid = valid3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            valid3_q <= 1'b0;
        end else begin
            if (load1) valid1_q <= in_valid;
            if (load2) valid2_q <= valid1_q;
            if (load3) valid3_q <= valid2_q;
        end
    end

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_BK_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the external carry-in is ignored.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // ------------------------------------------------------------------
    // Stage 1: bitwise generate/propagate and carry-in
    // ------------------------------------------------------------------
    gp_t [WIDTH-1:0] gp1_q;
    logic            cin1_q;

    always_ff @(posedge clk) begin
        if (load1 && in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                gp1_q[i].g <= a[i] & b_eff[i];
                gp1_q[i].p <= a[i] ^ b_eff[i];
            end
            cin1_q <= cin_eff;
        end
    end

    // ------------------------------------------------------------------
    // Brent-Kung prefix tree: Log2W up-sweep levels, Log2W-1 down-sweep
    // levels. Level 0 folds cin into bit 0 so every group reaching bit 0
    // yields the true carry out of its top bit.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= NumLevels; l++) begin : g_lvl
        gp_t [WIDTH-1:0] gp;

        if (l == 0) begin : g_init
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i == 0) begin : g_cin
                    assign gp[i] = '{g: gp1_q[0].g | (gp1_q[0].p & cin1_q), p: gp1_q[0].p};
                end else begin : g_copy
                    assign gp[i] = gp1_q[i];
                end
            end
        end else begin : g_comb
            localparam bit Up = (l <= Log2W);
            localparam int unsigned Span =
                Up ? (32'd1 << l) : (32'd1 << (2 * Log2W - l));
            localparam int unsigned Dist = Span / 2;

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                localparam bit Comb = Up ? (((i + 1) % Span) == 0)
                                         : ((((i + 1) % Span) == Dist) && (i >= Span));
                if (Comb) begin : g_cell
                    bk_prefix_cell u_cell (
                        .hi  (g_lvl[l-1].gp[i]),
                        .lo  (g_lvl[l-1].gp[i-Dist]),
                        .grp (gp[i])
                    );
                end else begin : g_pass
                    assign gp[i] = g_lvl[l-1].gp[i];
                end
            end
        end

        // Group propagates at the last level have no consumer.
        if (l == NumLevels) begin : g_sink
            logic unused_p;
            assign unused_p = ^gp;
        end
    end

    logic [WIDTH:0] carry;

    always_comb begin
        carry[0] = cin1_q;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = g_lvl[NumLevels].gp[i].g;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: prefix carries plus the bitwise propagates needed for the sum
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry2_q;
    logic [WIDTH-1:0] prop2_q;

    always_ff @(posedge clk) begin
        if (load2 && valid1_q) begin
            carry2_q <= carry;
            for (int i = 0; i < WIDTH; i++) begin
                prop2_q[i] <= gp1_q[i].p;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sum and carry-out, held while downstream stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else if (load3 && valid2_q) begin
            s    <= prop2_q ^ carry2_q[WIDTH-1:0];
            cout <= carry2_q[WIDTH];
        end
    end

endmodule

// File: tb/tb_pipelined_bk_adder.sv
// Bench for pipelined_bk_adder at WIDTH=16: vector table, back-to-back, backpressure,
// mid-flight reset and a randomized sweep scored against plain a+b+cin arithmetic.
module tb_pipelined_bk_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic         cin, cout, sub_v;
    logic [W-1:0] a, b, s;

    int errors    = 0;
    int checks    = 0;
    int delivered = 0;

    logic [W:0] exp_q[$];
    logic       smp_in_ready, smp_out_valid;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipelined_bk_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_BK_ADDER_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
    );

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb);
        if (sb) return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // One clock: sample handshakes at the negedge, score outputs, return after posedge+1.
    task automatic tick(output bit acc);
        @(negedge clk);
        smp_in_ready  = in_ready;
        smp_out_valid = out_valid;
        acc = !rst && in_valid && in_ready;
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_spurious: out_valid=1 s=%0h, expected no beat", s);
                end else begin
                    check("sb_data", {cout, s}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
            if (acc) exp_q.push_back(model(a, b, cin, sub_v));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single_beat(input string name, input vec_t v);
        bit acc;
        int lat;
        out_ready = 1'b1;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        sub_v     = v.sub;
        in_valid  = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        check({name, "_acc"}, acc, 1);
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick(acc);
            lat++;
        end
        check({name, "_lat"}, lat, 3);
        check({name, "_sum"}, {cout, s}, {v.cout, v.s});
        tick(acc);
    endtask

    initial begin
        bit acc;
        int nxt;
        int start_del;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_v     = 1'b0;

        vecs.push_back('{a: 16'hffff, b: 16'h0001, cin: 0, sub: 0, s: 16'h0000, cout: 1});
        vecs.push_back('{a: 16'h0000, b: 16'h0000, cin: 0, sub: 0, s: 16'h0000, cout: 0});
        vecs.push_back('{a: 16'h0000, b: 16'h0000, cin: 1, sub: 0, s: 16'h0001, cout: 0});
        vecs.push_back('{a: 16'hffff, b: 16'hffff, cin: 1, sub: 0, s: 16'hffff, cout: 1});
        vecs.push_back('{a: 16'hffff, b: 16'h0000, cin: 1, sub: 0, s: 16'h0000, cout: 1});
        vecs.push_back('{a: 16'h1234, b: 16'h4321, cin: 0, sub: 0, s: 16'h5555, cout: 0});
        vecs.push_back('{a: 16'h8000, b: 16'h8000, cin: 0, sub: 0, s: 16'h0000, cout: 1});
        vecs.push_back('{a: 16'haaaa, b: 16'h5555, cin: 1, sub: 0, s: 16'h0000, cout: 1});
        vecs.push_back('{a: 16'h7fff, b: 16'h0001, cin: 0, sub: 0, s: 16'h8000, cout: 0});
        vecs.push_back('{a: 16'h00ff, b: 16'h0001, cin: 0, sub: 0, s: 16'h0100, cout: 0});
        vecs.push_back('{a: 16'h0f0f, b: 16'hf0f0, cin: 0, sub: 0, s: 16'hffff, cout: 0});
`ifdef PIPELINED_BK_ADDER_SUB_EN
        vecs.push_back('{a: 16'h0005, b: 16'h0007, cin: 0, sub: 1, s: 16'hfffe, cout: 0});
        vecs.push_back('{a: 16'h0007, b: 16'h0005, cin: 0, sub: 1, s: 16'h0002, cout: 1});
        vecs.push_back('{a: 16'h0005, b: 16'h0007, cin: 1, sub: 1, s: 16'hfffe, cout: 0});
        vecs.push_back('{a: 16'h1234, b: 16'h1234, cin: 0, sub: 1, s: 16'h0000, cout: 1});
`endif

        // Reset state
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("reset_state", {out_valid, in_ready, cout, s}, {1'b1, 1'b0, {W{1'b0}}} << 1 >> 1 | (64'd1 << (W + 1)));
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            single_beat($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back: a=i, b=2i, cin=1
        out_ready = 1'b1;
        sub_v     = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                a        = W'(c);
                b        = W'(2 * c);
                cin      = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 3 && c < 11) begin
                check($sformatf("b2b_out%0d", c - 3), {out_valid, cout, s},
                      {1'b1, 1'b0, W'(3 * (c - 3) + 1)});
            end else if (c == 11) begin
                check("b2b_end", out_valid, 0);
            end
            tick(acc);
        end

        // Backpressure: out_ready low for the first 5 cycles while streaming
        nxt       = 0;
        start_del = delivered;
        for (int c = 0; c < 24; c++) begin
            out_ready = (c >= 5);
            in_valid  = (nxt < 6);
            a         = W'(32'h0100 + nxt);
            b         = W'(nxt * 32'h0011);
            cin       = nxt[0];
            tick(acc);
            if (c < 8) begin
                check($sformatf("bp_in_ready%0d", c), smp_in_ready, (c == 3 || c == 4) ? 0 : 1);
            end
            if (acc) nxt++;
        end
        check("bp_delivered", delivered - start_del, 6);
        check("bp_drained", exp_q.size(), 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        cin       = 1'b0;
        tick(acc);
        a = 16'h3333;
        b = 16'h4444;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        check("rst_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_immediate", {out_valid, in_ready}, 2'b01);
        exp_q.delete();
        tick(acc);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(acc);
            check($sformatf("rst_no_emit%0d", c), smp_out_valid, 0);
        end
        single_beat("rst_next", '{a: 16'h0101, b: 16'h0202, cin: 1, sub: 0, s: 16'h0304, cout: 0});

        // Randomized sweep with random backpressure
        for (int c = 0; c < 20000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a         = W'($urandom);
            b         = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = '1;
            cin = 1'($urandom);
`ifdef PIPELINED_BK_ADDER_SUB_EN
            sub_v = 1'($urandom);
`endif
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            tick(acc);
        end
        check("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
